// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-channel round-robin/fixed-priority bus arbiter with watchdog preemption
module rr_arbiter_n #(
    parameter int NUM_CH         = 4,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int WD_TIMER_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           prio_mode,
    input  logic [NUM_CH-1:0]              req,
    output logic [NUM_CH-1:0]              ack,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   address_ch,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   wrdata_ch,
    input  logic [NUM_CH-1:0]              rdWrn_ch,
    output logic [NUM_CH*DATA_WIDTH-1:0]   rddata_ch,
    output logic [ADDR_WIDTH-1:0]          address,
    output logic [DATA_WIDTH-1:0]          wrdata,
    input  logic [DATA_WIDTH-1:0]          rddata,
    output logic                           rdWrn,
    output logic                           busy,
    output logic [$clog2(NUM_CH)-1:0]      grant_id,
    output logic [NUM_CH-1:0]              timeout,
    input  logic [NUM_CH-1:0]              timeout_clr
);
    localparam int IDW = $clog2(NUM_CH);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [NUM_CH-1:0]         ack_q, ack_d;
    logic                      busy_q, busy_d;
    logic [IDW-1:0]            grant_id_q, grant_id_d;
    logic [IDW-1:0]            last_grant_q, last_grant_d;
    logic [WD_TIMER_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
    logic [NUM_CH-1:0]         timeout_q, timeout_d;
    logic [NUM_CH-1:0]         blocked_q, blocked_d;

    logic [NUM_CH-1:0]         eligible;
    logic                      win_found;
    logic [IDW-1:0]            win_id;

    // Candidate order: ascending index in fixed mode, rotating past last_grant otherwise.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_id    = '0;
        eligible  = req & ~blocked_q;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = prio_mode ? (i - 1) : ((int'(last_grant_q) + i) % NUM_CH);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_id    = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        busy_d       = busy_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        wd_cnt_d     = wd_cnt_q;
        timeout_d    = timeout_q & ~timeout_clr;
        blocked_d    = blocked_q & req;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d         = GRANT;
                    ack_d           = '0;
                    ack_d[win_id]   = 1'b1;
                    busy_d          = 1'b1;
                    grant_id_d      = win_id;
                    last_grant_d    = win_id;
                    wd_cnt_d        = '0;
                end
            end
            GRANT: begin
                if (!req[grant_id_q] || (&wd_cnt_q)) begin
                    state_d    = IDLE;
                    ack_d      = '0;
                    busy_d     = 1'b0;
                    grant_id_d = '0;
                    // Holding req past the last watchdog cycle is a forced release.
                    if (req[grant_id_q]) begin
                        timeout_d[grant_id_q] = 1'b1;
                        blocked_d[grant_id_q] = 1'b1;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            busy_q       <= 1'b0;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NUM_CH - 1);
            wd_cnt_q     <= '0;
            timeout_q    <= '0;
            blocked_q    <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= timeout_d;
            blocked_q    <= blocked_d;
        end
    end

    always_comb begin
        address   = '0;
        wrdata    = '0;
        rdWrn     = 1'b1;
        rddata_ch = '0;
        if (busy_q) begin
            address = address_ch[int'(grant_id_q)*ADDR_WIDTH +: ADDR_WIDTH];
            wrdata  = wrdata_ch[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
            rdWrn   = rdWrn_ch[grant_id_q];
            rddata_ch[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH] = rddata;
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign timeout  = timeout_q;

endmodule
